cskip_sub_10bit_seq: RTL and testbench

Multi-cycle 10-bit carry-skip subtractor computing `diff = minuend - subtrahend` and a borrow-out, one skip block per clock (block widths 4/4/2, matching the datapath's 10-bit carry-skip adder partition). It sits beside the carry-skip adder as its inverse-direction arithmetic unit. It accepts operands over a valid/ready handshake, iterates the skip chain, and holds the result until the consumer takes it.

---
 rtl/cskip_sub_pkg.sv | 27 ++
 rtl/cskip_sub_blk.sv | 36 +++
 rtl/cskip_sub_10bit_seq.sv | 139 +++++++++++++
 tb/tb_cskip_sub_10bit_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cskip_sub_pkg.sv
// Shared constants and FSM state type for the 10-bit carry-skip subtractor.
// The 4/4/2 block partition matches the companion carry-skip adder.
package cskip_sub_pkg;

    localparam int unsigned WIDTH = 10;
    localparam int unsigned BLK_W = 4;

    // Bit ranges of the three skip blocks
    localparam int unsigned BLK0_LO = 0;
    localparam int unsigned BLK0_HI = 3;
    localparam int unsigned BLK1_LO = 4;
    localparam int unsigned BLK1_HI = 7;
    localparam int unsigned BLK2_LO = 8;
    localparam int unsigned BLK2_HI = 9;

    // Unused upper bits when the narrow last block runs through the BLK_W-wide slice
    localparam int unsigned BLK2_PAD_W = BLK_W - (BLK2_HI - BLK2_LO + 1);

    typedef enum logic [2:0] {
        StIdle,
        StBlk0,
        StBlk1,
        StBlk2,
        StDone
    } cskip_sub_state_t;

endpackage

// File: rtl/cskip_sub_blk.sv
// One combinational carry-skip block computing a + ~b + cin over W bits.
// Carry-out bypasses the ripple when every bit propagates.
module cskip_sub_blk #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_diff,
    output logic         o_cout,
    output logic         o_skip
);

    logic [W-1:0] w_p;
    logic [W-1:0] w_g;
    logic         w_carry;
    logic         w_ripple_cout;

    assign w_p = i_a ^ ~i_b;
    assign w_g = i_a & ~i_b;

    // Ripple the block bits to form the per-bit difference and ripple carry-out
    always_comb begin
        o_diff  = '0;
        w_carry = i_cin;
        for (int i = 0; i < int'(W); i++) begin
            o_diff[i] = w_p[i] ^ w_carry;
            w_carry   = w_g[i] | (w_p[i] & w_carry);
        end
        w_ripple_cout = w_carry;
    end

    assign o_skip = &w_p;
    assign o_cout = o_skip ? i_cin : w_ripple_cout;

endmodule

// File: rtl/cskip_sub_10bit_seq.sv
// Multi-cycle 10-bit carry-skip subtractor, one skip block per clock.
// Optional feature macro: CSKIP_SUB_SKIP_CNT_EN adds the skip_cnt port/register.
module cskip_sub_10bit_seq #(
    parameter int unsigned WIDTH = cskip_sub_pkg::WIDTH,
    parameter int unsigned BLK_W = cskip_sub_pkg::BLK_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef CSKIP_SUB_SKIP_CNT_EN
    output logic [1:0]       skip_cnt,
`endif
    output logic             bout
);

    import cskip_sub_pkg::*;

    cskip_sub_state_t r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic [BLK_W-1:0] w_blk_a;
    logic [BLK_W-1:0] w_blk_b;
    logic [BLK_W-1:0] w_blk_diff;
    logic             w_blk_cout;
    logic             w_blk_skip;
    logic             w_accept;

    assign in_ready  = (r_state == StIdle) && !rst;
    assign out_valid = (r_state == StDone);
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign w_accept  = in_valid && in_ready;

    // Route the operand slice of the active block into the shared skip block.
    // The last block is padded with a=1/b=1 bits, which propagate without generating.
    always_comb begin
        w_blk_a = r_a[BLK0_HI:BLK0_LO];
        w_blk_b = r_b[BLK0_HI:BLK0_LO];
        unique case (r_state)
            StBlk1: begin
                w_blk_a = r_a[BLK1_HI:BLK1_LO];
                w_blk_b = r_b[BLK1_HI:BLK1_LO];
            end
            StBlk2: begin
                w_blk_a = {{BLK2_PAD_W{1'b1}}, r_a[BLK2_HI:BLK2_LO]};
                w_blk_b = {{BLK2_PAD_W{1'b1}}, r_b[BLK2_HI:BLK2_LO]};
            end
            default: ;
        endcase
    end

    cskip_sub_blk #(
        .W (BLK_W)
    ) u_blk (
        .i_a    (w_blk_a),
        .i_b    (w_blk_b),
        .i_cin  (r_carry),
        .o_diff (w_blk_diff),
        .o_cout (w_blk_cout),
        .o_skip (w_blk_skip)
    );

    // Sequencer: accept operands, walk the three blocks, hold the result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_a     <= minuend;
                        r_b     <= subtrahend;
                        r_carry <= 1'b1;
                        r_state <= StBlk0;
                    end
                end
                StBlk0: begin
                    r_diff[BLK0_HI:BLK0_LO] <= w_blk_diff;
                    r_carry                 <= w_blk_cout;
                    r_state                 <= StBlk1;
                end
                StBlk1: begin
                    r_diff[BLK1_HI:BLK1_LO] <= w_blk_diff;
                    r_carry                 <= w_blk_cout;
                    r_state                 <= StBlk2;
                end
                StBlk2: begin
                    r_diff[BLK2_HI:BLK2_LO] <= w_blk_diff[BLK2_HI-BLK2_LO:0];
                    r_carry                 <= w_blk_cout;
                    r_bout                  <= ~w_blk_cout;
                    r_state                 <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef CSKIP_SUB_SKIP_CNT_EN
    logic [1:0] r_skip_cnt;

    assign skip_cnt = r_skip_cnt;

    // Count blocks whose carry bypassed the ripple; at most three, so no wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_skip_cnt <= '0;
        end else if (w_accept) begin
            r_skip_cnt <= '0;
        end else if ((r_state == StBlk0 || r_state == StBlk1 || r_state == StBlk2)
                     && w_blk_skip) begin
            r_skip_cnt <= r_skip_cnt + 2'd1;
        end
    end
`else
    logic w_unused_skip;
    assign w_unused_skip = w_blk_skip;
`endif

endmodule

// File: tb/tb_cskip_sub_10bit_seq.sv
// Self-checking bench for cskip_sub_10bit_seq: directed table, random vectors against
// an arithmetic reference model, backpressure and mid-operation reset sequences.
module tb_cskip_sub_10bit_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] minuend;
    logic [9:0] subtrahend;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] diff;
    logic       bout;
`ifdef CSKIP_SUB_SKIP_CNT_EN
    logic [1:0] skip_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cskip_sub_10bit_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
`ifdef CSKIP_SUB_SKIP_CNT_EN
        .skip_cnt   (skip_cnt),
`endif
        .bout       (bout)
    );

    typedef struct {
        logic [9:0] d;
        logic       bo;
        int         sk;
    } res_t;

    typedef struct {
        logic [9:0] a;
        logic [9:0] b;
        logic [9:0] exp_d;
        logic       exp_bo;
        int         exp_sk;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain modular subtraction; a block skips exactly when its slices are equal
    function automatic res_t model(input logic [9:0] a, input logic [9:0] b);
        res_t r;
        int   ia = int'(a);
        int   ib = int'(b);
        r.d  = 10'((ia - ib + 1024) % 1024);
        r.bo = (ia < ib);
        r.sk = int'(a[3:0] == b[3:0]) + int'(a[7:4] == b[7:4]) + int'(a[9:8] == b[9:8]);
        return r;
    endfunction

    // Present operands at a falling edge, wait for acceptance and then for out_valid.
    // lat counts falling edges from the accepting cycle to the first with out_valid.
    task automatic send(input logic [9:0] a, input logic [9:0] b, output res_t got,
                        output int lat);
        int w;
        minuend    = a;
        subtrahend = b;
        in_valid   = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("accept_wait", int'(in_ready), 1);
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 20);
        got.d  = diff;
        got.bo = bout;
`ifdef CSKIP_SUB_SKIP_CNT_EN
        got.sk = int'(skip_cnt);
`else
        got.sk = 0;
`endif
    endtask

    task automatic check_res(input string tag, input res_t got, input logic [9:0] ed,
                             input logic ebo, input int esk);
        check({tag, "_diff"}, int'(got.d), int'(ed));
        check({tag, "_bout"}, int'(got.bo), int'(ebo));
`ifdef CSKIP_SUB_SKIP_CNT_EN
        check({tag, "_skip_cnt"}, got.sk, esk);
`else
        if (esk < 0) $display("unreachable");
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        res_t got;
        res_t exp;
        int   lat;

        // Skip counts follow the propagate rule: a block skips when a slice equals b slice
        vecs[0] = '{10'd5,     10'd3,     10'd2,     1'b0, 2};
        vecs[1] = '{10'd3,     10'd5,     10'h3FE,   1'b1, 2};
        vecs[2] = '{10'h155,   10'h155,   10'd0,     1'b0, 3};
        vecs[3] = '{10'd0,     10'h3FF,   10'd1,     1'b1, 0};
        vecs[4] = '{10'h3FF,   10'd0,     10'h3FF,   1'b0, 0};
        vecs[5] = '{10'd7,     10'd2,     10'd5,     1'b0, 2};

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        minuend    = '0;
        subtrahend = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_bout", int'(bout), 0);
`ifdef CSKIP_SUB_SKIP_CNT_EN
        check("rst_skip_cnt", int'(skip_cnt), 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].a, vecs[i].b, got, lat);
            check("tbl_latency", lat, 4);
            check("tbl_out_valid", int'(out_valid), 1);
            check_res("tbl", got, vecs[i].exp_d, vecs[i].exp_bo, vecs[i].exp_sk);
        end

        // Random operands against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [9:0] ra;
            logic [9:0] rb;
            ra = 10'($urandom_range(0, 1023));
            rb = (i % 5 == 0) ? ra : 10'($urandom_range(0, 1023));
            exp = model(ra, rb);
            send(ra, rb, got, lat);
            check("rnd_latency", lat, 4);
            check_res("rnd", got, exp.d, exp.bo, exp.sk);
        end

        // Backpressure: result held, new operands ignored while DONE
        @(negedge clk);
        out_ready = 1'b0;
        exp = model(10'h2A5, 10'h13C);
        send(10'h2A5, 10'h13C, got, lat);
        check("bp_latency", lat, 4);
        check_res("bp", got, exp.d, exp.bo, exp.sk);
        for (int i = 0; i < 6; i++) begin
            in_valid   = 1'b1;
            minuend    = 10'h011;
            subtrahend = 10'h022;
            @(negedge clk);
            check("bp_hold_diff", int'(diff), int'(exp.d));
            check("bp_hold_bout", int'(bout), int'(exp.bo));
            check("bp_hold_in_ready", int'(in_ready), 0);
            check("bp_hold_out_valid", int'(out_valid), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", int'(out_valid), 0);
        check("bp_release_in_ready", int'(in_ready), 1);
        @(negedge clk);
        check("bp_no_ghost_out_valid", int'(out_valid), 0);
        check("bp_diff_kept", int'(diff), int'(exp.d));

        // Reset asserted while BLK1 is active discards the operation
        minuend    = 10'd9;
        subtrahend = 10'd4;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_diff", int'(diff), 0);
        check("mid_rst_bout", int'(bout), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_recover_in_ready", int'(in_ready), 1);
        check("mid_rst_recover_out_valid", int'(out_valid), 0);
        send(10'd7, 10'd2, got, lat);
        check("after_rst_latency", lat, 4);
        check_res("after_rst", got, 10'd5, 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
